// File: rtl/timer_mux_n.sv
// N-digit BCD up/down timer with prescaler and round-robin display scan.
// Optional `define LAP_HOLD_EN adds a lap input that freezes the displayed value.
module timer_mux_n #(
  parameter int CLK_DIV_INT = 5,
  parameter int N_DIGITS    = 2,
  parameter int MAX_COUNT   = 59,
  parameter int SCAN_DIV    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pause,
  input  logic                  count_down,
  input  logic                  clear,
`ifdef LAP_HOLD_EN
  input  logic                  lap,
`endif
  output logic [4*N_DIGITS-1:0] digits_bcd,
  output logic [3:0]            muxed_digit,
  output logic [N_DIGITS-1:0]   digit_en,
  output logic                  tick,
  output logic                  wrap
);

  localparam int CW = 4 * N_DIGITS;
  localparam int PW = (CLK_DIV_INT > 1) ? $clog2(CLK_DIV_INT) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  function automatic logic [CW-1:0] to_bcd(input int value);
    logic [CW-1:0] r;
    int            rest;
    r    = '0;
    rest = value;
    for (int i = 0; i < N_DIGITS; i++) begin
      r[4*i +: 4] = 4'(rest % 10);
      rest        = rest / 10;
    end
    return r;
  endfunction

  localparam logic [CW-1:0] MAX_BCD = to_bcd(MAX_COUNT);

  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] count_q, count_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_inc, cnt_dec, disp;
  logic          inc_carry, dec_borrow;
  logic          tick_en, scan_step;

  assign tick_en   = !pause && (presc_q == PW'(CLK_DIV_INT - 1));
  assign scan_step = (scan_cnt_q == SW'(SCAN_DIV - 1));

  // Ripple decimal carry/borrow across the digits.
  always_comb begin
    cnt_inc    = count_q;
    cnt_dec    = count_q;
    inc_carry  = 1'b1;
    dec_borrow = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (inc_carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          cnt_inc[4*i +: 4] = 4'd0;
        end else begin
          cnt_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          inc_carry         = 1'b0;
        end
      end
      if (dec_borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          cnt_dec[4*i +: 4] = 4'd9;
        end else begin
          cnt_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          dec_borrow        = 1'b0;
        end
      end
    end
  end

  always_comb begin
    presc_d    = presc_q;
    count_d    = count_q;
    tick_d     = 1'b0;
    wrap_d     = 1'b0;
    scan_cnt_d = scan_step ? '0 : scan_cnt_q + SW'(1);
    idx_d      = idx_q;
    if (scan_step) begin
      idx_d = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
    if (clear) begin
      presc_d = '0;
      count_d = '0;
    end else begin
      if (!pause) begin
        presc_d = tick_en ? '0 : presc_q + PW'(1);
      end
      if (tick_en) begin
        tick_d = 1'b1;
        if (count_down) begin
          if (count_q == '0) begin
            count_d = MAX_BCD;
            wrap_d  = 1'b1;
          end else begin
            count_d = cnt_dec;
          end
        end else if (count_q == MAX_BCD) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      count_q    <= '0;
      tick_q     <= 1'b0;
      wrap_q     <= 1'b0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
    end else begin
      presc_q    <= presc_d;
      count_q    <= count_d;
      tick_q     <= tick_d;
      wrap_q     <= wrap_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
    end
  end

`ifdef LAP_HOLD_EN
  logic          lap_q, lap_d;
  logic [CW-1:0] hold_q, hold_d;

  // Capture on the sampled rising edge of lap; the registered lap selects the hold.
  always_comb begin
    lap_d  = lap;
    hold_d = hold_q;
    if (clear) begin
      hold_d = '0;
    end else if (lap && !lap_q) begin
      hold_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lap_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      lap_q  <= lap_d;
      hold_q <= hold_d;
    end
  end

  assign disp = lap_q ? hold_q : count_q;
`else
  assign disp = count_q;
`endif

  always_comb begin
    muxed_digit = 4'd0;
    digit_en    = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        muxed_digit = disp[4*i +: 4];
        digit_en[i] = 1'b1;
      end
    end
  end

  assign digits_bcd = disp;
  assign tick       = tick_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_timer_mux_n.sv
// Self-checking bench for timer_mux_n: a default instance (A) and a 3-digit,
// divide-by-1, scan-by-4 instance (B) checked every cycle against an arithmetic model.
module tb_timer_mux_n;

  logic        clk = 1'b0;
  logic        reset;
  logic        pause;
  logic        count_down;
  logic        clear;
`ifdef LAP_HOLD_EN
  logic        lap;
`endif
  logic [7:0]  digits_a;
  logic [3:0]  muxed_a;
  logic [1:0]  en_a;
  logic        tick_a, wrap_a;
  logic [11:0] digits_b;
  logic [3:0]  muxed_b;
  logic [2:0]  en_b;
  logic        tick_b, wrap_b;

  int  pass_cnt  = 0;
  int  total_cnt = 0;
  bit  check_en  = 1'b0;

  int  m_presc[2], m_count[2], m_sc[2], m_idx[2], m_hold[2];
  bit  m_tick[2], m_wrap[2], m_lap_q[2];

  always #5 clk = ~clk;

  timer_mux_n dut_a (
    .clk(clk), .reset(reset), .pause(pause), .count_down(count_down), .clear(clear),
`ifdef LAP_HOLD_EN
    .lap(lap),
`endif
    .digits_bcd(digits_a), .muxed_digit(muxed_a), .digit_en(en_a), .tick(tick_a), .wrap(wrap_a)
  );

  timer_mux_n #(.CLK_DIV_INT(1), .N_DIGITS(3), .MAX_COUNT(199), .SCAN_DIV(4)) dut_b (
    .clk(clk), .reset(reset), .pause(pause), .count_down(count_down), .clear(clear),
`ifdef LAP_HOLD_EN
    .lap(lap),
`endif
    .digits_bcd(digits_b), .muxed_digit(muxed_b), .digit_en(en_b), .tick(tick_b), .wrap(wrap_b)
  );

  function automatic int p_div(input int k);  return (k == 0) ? 5  : 1;   endfunction
  function automatic int p_max(input int k);  return (k == 0) ? 59 : 199; endfunction
  function automatic int p_nd(input int k);   return (k == 0) ? 2  : 3;   endfunction
  function automatic int p_sd(input int k);   return (k == 0) ? 1  : 4;   endfunction

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
    return r;
  endfunction

  function automatic int shown(input int k);
`ifdef LAP_HOLD_EN
    return m_lap_q[k] ? m_hold[k] : m_count[k];
`else
    return m_count[k];
`endif
  endfunction

  // Behavioural model: plain modular arithmetic on integer counts.
  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_presc[k] <= 0; m_count[k] <= 0; m_tick[k] <= 0; m_wrap[k] <= 0;
        m_sc[k] <= 0; m_idx[k] <= 0; m_lap_q[k] <= 0; m_hold[k] <= 0;
      end else begin
        m_sc[k] <= (m_sc[k] + 1) % p_sd(k);
        if (m_sc[k] == p_sd(k) - 1) m_idx[k] <= (m_idx[k] + 1) % p_nd(k);
`ifdef LAP_HOLD_EN
        m_lap_q[k] <= lap;
        if (clear) m_hold[k] <= 0;
        else if (lap && !m_lap_q[k]) m_hold[k] <= m_count[k];
`endif
        if (clear) begin
          m_presc[k] <= 0; m_count[k] <= 0; m_tick[k] <= 0; m_wrap[k] <= 0;
        end else begin
          if (!pause) m_presc[k] <= (m_presc[k] + 1) % p_div(k);
          if (!pause && m_presc[k] == p_div(k) - 1) begin
            m_tick[k] <= 1;
            if (count_down) begin
              m_count[k] <= (m_count[k] + p_max(k)) % (p_max(k) + 1);
              m_wrap[k]  <= (m_count[k] == 0);
            end else begin
              m_count[k] <= (m_count[k] + 1) % (p_max(k) + 1);
              m_wrap[k]  <= (m_count[k] == p_max(k));
            end
          end else begin
            m_tick[k] <= 0;
            m_wrap[k] <= 0;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input logic p, input logic cd, input logic cl);
    pause      = p;
    count_down = cd;
    clear      = cl;
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("A.digits", 32'(digits_a), to_bcd(shown(0)));
      checkOutput("A.muxed",  32'(muxed_a),  32'((shown(0) / (10 ** m_idx[0])) % 10));
      checkOutput("A.en",     32'(en_a),     32'(1) << m_idx[0]);
      checkOutput("A.tick",   32'(tick_a),   32'(m_tick[0]));
      checkOutput("A.wrap",   32'(wrap_a),   32'(m_wrap[0]));
      checkOutput("B.digits", 32'(digits_b), to_bcd(shown(1)));
      checkOutput("B.muxed",  32'(muxed_b),  32'((shown(1) / (10 ** m_idx[1])) % 10));
      checkOutput("B.en",     32'(en_b),     32'(1) << m_idx[1]);
      checkOutput("B.tick",   32'(tick_b),   32'(m_tick[1]));
      checkOutput("B.wrap",   32'(wrap_b),   32'(m_wrap[1]));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit found;
    reset = 1'b1;
    applyStimulus(0, 0, 0);
`ifdef LAP_HOLD_EN
    lap = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("reset.A.digits", 32'(digits_a), 32'h00);
    checkOutput("reset.A.en",     32'(en_a),     32'b01);
    checkOutput("reset.B.en",     32'(en_b),     32'b001);
    check_en = 1'b1;
    #1 reset = 1'b0;

    // Count up: first tick after 5 clocks, 60 ticks wrap A; B reaches 100.
    repeat (5) @(negedge clk);
    checkOutput("up.A.first", 32'(digits_a), 32'h01);
    checkOutput("up.A.tick",  32'(tick_a),   32'h1);
    checkOutput("up.B.first", 32'(digits_b), 32'h005);
    repeat (295) @(negedge clk);
    checkOutput("up.A.wrapval", 32'(digits_a), 32'h00);
    checkOutput("up.A.wrap",    32'(wrap_a),   32'h1);
    checkOutput("up.B.300",     32'(digits_b), 32'h100);

    // Count down from reset, then a mid-period direction change.
    #1 reset = 1'b1;
    applyStimulus(0, 1, 0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("down.A.59",   32'(digits_a), 32'h59);
    checkOutput("down.A.wrap", 32'(wrap_a),   32'h1);
    checkOutput("down.B.195",  32'(digits_b), 32'h195);
    repeat (5) @(negedge clk);
    checkOutput("down.A.58",   32'(digits_a), 32'h58);
    repeat (2) @(negedge clk);
    #1 applyStimulus(0, 0, 0);
    repeat (3) @(negedge clk);
    checkOutput("dir.A.59",    32'(digits_a), 32'h59);
    checkOutput("dir.A.nowrap", 32'(wrap_a),  32'h0);

    // Pause with prescaler at 3.
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (m_presc[0] == 3) found = 1;
    end
    checkOutput("pause.reach", 32'(found), 32'h1);
    #1 applyStimulus(1, 0, 0);
    repeat (20) @(negedge clk);
    checkOutput("pause.A.hold", 32'(digits_a), 32'h59);
    #1 applyStimulus(0, 0, 0);
    repeat (2) @(negedge clk);
    checkOutput("pause.A.resume", 32'(digits_a), 32'h00);
    checkOutput("pause.A.wrap",   32'(wrap_a),   32'h1);

    // Clear in the tick_en cycle at count 37.
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (m_count[0] == 37 && m_presc[0] == 4) found = 1;
    end
    checkOutput("clear.reach", 32'(found), 32'h1);
    #1 applyStimulus(0, 0, 1);
    @(negedge clk);
    checkOutput("clear.A.digits", 32'(digits_a), 32'h00);
    checkOutput("clear.A.tick",   32'(tick_a),   32'h0);
    checkOutput("clear.A.wrap",   32'(wrap_a),   32'h0);
    #1 applyStimulus(0, 0, 0);
    repeat (5) @(negedge clk);
    checkOutput("clear.A.next", 32'(digits_a), 32'h01);

    // Asynchronous reset between edges.
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("areset.A.digits", 32'(digits_a), 32'h00);
    checkOutput("areset.A.muxed",  32'(muxed_a),  32'h0);
    checkOutput("areset.A.en",     32'(en_a),     32'b01);
    checkOutput("areset.B.en",     32'(en_b),     32'b001);
    checkOutput("areset.B.tick",   32'(tick_b),   32'h0);
    @(negedge clk);
    #1 reset = 1'b0;

`ifdef LAP_HOLD_EN
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (m_count[0] == 12) found = 1;
    end
    checkOutput("lap.reach", 32'(found), 32'h1);
    #1 lap = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("lap.A.held", 32'(digits_a), 32'h12);
    #1 lap = 1'b0;
    repeat (2) @(negedge clk);
`endif

    // Mixed directed sequence: down with pause bursts, then clear.
    for (int i = 0; i < 12; i++) begin
      #1 applyStimulus((i % 4) == 3, (i % 3) != 0, i == 9);
      repeat (7) @(negedge clk);
    end
    #1 applyStimulus(0, 0, 0);
    repeat (10) @(negedge clk);

    check_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
